// File: rtl/pipeline_pkg.sv
// Shared pipeline types: the result/writeback packet and the default depth
// of the per-unit writeback result queue.
package pipeline_pkg;

    localparam int WB_QUEUE_DEPTH_DEFAULT = 2;

    typedef struct packed {
        logic        valid;
        logic        wren;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] data;
    } pipe_t;

endpackage

// File: rtl/wb_result_queue.sv
// Small FIFO between a multi-cycle unit and the writeback arbiter.
// Optional macro WB_QUEUE_BYPASS_EN lets a result reach o_wb_pkg in the same cycle when the queue is empty.
module wb_result_queue
    import pipeline_pkg::*;
#(
    parameter int DEPTH = WB_QUEUE_DEPTH_DEFAULT
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_flush,
    input  pipe_t                      i_result_pkg,
    output logic                       o_ready,
    output pipe_t                      o_wb_pkg,
    input  logic                       i_ack,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    pipe_t            mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    logic  push_req;
    logic  pop;
    logic  store;
    pipe_t head;

    assign o_full   = (count_reg == CNT_W'(DEPTH));
    assign o_empty  = (count_reg == '0);
    assign o_ready  = !o_full;
    assign o_count  = count_reg;

    assign push_req = i_result_pkg.valid & i_result_pkg.wren & o_ready;
    assign pop      = i_ack & !o_empty;

`ifdef WB_QUEUE_BYPASS_EN
    logic bypass_hit;
    // An empty queue forwards the incoming result; if it is acked at once it never needs storing.
    assign bypass_hit = o_empty & push_req & !i_flush;
    assign store      = push_req & !(bypass_hit & i_ack);
`else
    assign store      = push_req;
`endif

    always_comb begin
        count_next = count_reg;
        case ({store, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (store)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (store && !i_rst && !i_flush)
            mem[wr_ptr_reg] <= i_result_pkg;
    end

    assign head = o_empty ? pipe_t'('0) : mem[rd_ptr_reg];

`ifdef WB_QUEUE_BYPASS_EN
    assign o_wb_pkg = bypass_hit ? i_result_pkg : head;
`else
    assign o_wb_pkg = head;
`endif

endmodule
